// File: rtl/alu_issue_pkg.sv
// Shared widths, ALU operation codes and RV32I decode constants for the issue stage.
package alu_issue_pkg;

    localparam int XLEN   = 32;
    localparam int ALUOPS = 4;

    typedef enum logic [ALUOPS-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NEQ  = 4'd11,
        ALU_GE   = 4'd12,
        ALU_GEU  = 4'd13
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [XLEN-1:0] data_1;
        logic [XLEN-1:0] data_2;
        logic [XLEN-1:0] imm;
        logic [4:0]      shamt;
        logic [4:0]      rd;
        logic            wb_en;
        logic            is_branch;
        logic            is_mem;
        logic            is_system;
        logic            illegal;
    } issue_t;

    // Base (funct7 = 0) mapping shared by OP and OP-IMM.
    function automatic alu_op_e alu_f3_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction handshake in, ALU operands and sidecar fields out.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic              i_valid;
    logic              o_ready;
    logic [31:0]       i_instr;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_rs1_data;
    logic [XLEN-1:0]   i_rs2_data;
    logic              o_valid;
    logic              i_ready;
    logic [ALUOPS-1:0] o_alu_op;
    logic [XLEN-1:0]   o_data_1;
    logic [XLEN-1:0]   o_data_2;
    logic [4:0]        o_shamt;
    logic [4:0]        o_rd;
    logic              o_wb_en;
    logic              o_is_branch;
    logic [XLEN-1:0]   o_imm;
    logic              o_is_mem;
    logic              o_is_system;
    logic              o_illegal;

    modport slave (
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
        output o_ready, o_valid, o_alu_op, o_data_1, o_data_2, o_shamt, o_rd,
               o_wb_en, o_is_branch, o_imm, o_is_mem, o_is_system, o_illegal
    );

    modport master (
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ready,
        input  o_ready, o_valid, o_alu_op, o_data_1, o_data_2, o_shamt, o_rd,
               o_wb_en, o_is_branch, o_imm, o_is_mem, o_is_system, o_illegal
    );

endinterface

// File: rtl/alu_issue_imm_gen.sv
// RV32I immediate extraction; every format is sign-extended from instr[31].
module alu_issue_imm_gen
    import alu_issue_pkg::*;
(
    input  logic [31:7]     instr_i,
    output logic [XLEN-1:0] imm_i_o,
    output logic [XLEN-1:0] imm_s_o,
    output logic [XLEN-1:0] imm_b_o,
    output logic [XLEN-1:0] imm_u_o,
    output logic [XLEN-1:0] imm_j_o
);

    assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
    assign imm_u_o = {instr_i[31:12], 12'b0};
    assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes one RV32I instruction into ALU op/operands plus
// writeback/branch sidecar fields, held in a single flushable pipeline register.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    alu_issue_if.slave  bus
);

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            illegal;
    issue_t          dec;
    issue_t          issue_q, issue_d;
    logic            valid_q, valid_d;
    logic            load;

    assign instr  = bus.i_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    alu_issue_imm_gen u_imm_gen (
        .instr_i (instr[31:7]),
        .imm_i_o (imm_i),
        .imm_s_o (imm_s),
        .imm_b_o (imm_b),
        .imm_u_o (imm_u),
        .imm_j_o (imm_j)
    );

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.rd     = instr[11:7];
        illegal    = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec.data_1 = bus.i_rs1_data;
                    dec.data_2 = bus.i_rs2_data;
                    dec.wb_en  = 1'b1;
                    if (funct7 == F7_BASE)
                        dec.alu_op = alu_f3_op(funct3);
                    else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
                        dec.alu_op = (funct3 == F3_ADD) ? ALU_SUB : ALU_SRA;
                    else
                        illegal = 1'b1;
                    // The ALU shifts by the whole of operand B, so trim it to 5 bits here.
                    if (funct3 == F3_SLL || funct3 == F3_SR)
                        dec.data_2 = {27'b0, bus.i_rs2_data[4:0]};
                end
                OPC_OP_IMM: begin
                    dec.data_1 = bus.i_rs1_data;
                    dec.data_2 = imm_i;
                    dec.wb_en  = 1'b1;
                    dec.alu_op = alu_f3_op(funct3);
                    if (funct3 == F3_SLL || funct3 == F3_SR) begin
                        dec.data_2 = {27'b0, instr[24:20]};
                        if (funct3 == F3_SR && funct7 == F7_ALT)
                            dec.alu_op = ALU_SRA;
                        else if (funct7 != F7_BASE)
                            illegal = 1'b1;
                    end
                end
                OPC_LUI: begin
                    dec.data_2 = imm_u;
                    dec.wb_en  = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.data_1 = bus.i_pc;
                    dec.data_2 = imm_u;
                    dec.wb_en  = 1'b1;
                end
                OPC_JAL, OPC_JALR: begin
                    dec.data_1 = bus.i_pc;
                    dec.data_2 = 32'd4;
                    dec.wb_en  = 1'b1;
                    dec.imm    = (opcode == OPC_JAL) ? imm_j : imm_i;
                    if (opcode == OPC_JALR && funct3 != 3'd0)
                        illegal = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.data_1    = bus.i_rs1_data;
                    dec.data_2    = bus.i_rs2_data;
                    dec.imm       = imm_b;
                    dec.is_branch = 1'b1;
                    case (funct3)
                        F3_BEQ:  dec.alu_op = ALU_EQ;
                        F3_BNE:  dec.alu_op = ALU_NEQ;
                        F3_BLT:  dec.alu_op = ALU_SLT;
                        F3_BGE:  dec.alu_op = ALU_GE;
                        F3_BLTU: dec.alu_op = ALU_SLTU;
                        F3_BGEU: dec.alu_op = ALU_GEU;
                        default: illegal    = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    dec.data_1 = bus.i_rs1_data;
                    dec.data_2 = imm_i;
                    dec.is_mem = 1'b1;
                    dec.wb_en  = 1'b1;
                end
                OPC_STORE: begin
                    dec.data_1 = bus.i_rs1_data;
                    dec.data_2 = imm_s;
                    dec.imm    = imm_s;
                    dec.is_mem = 1'b1;
                end
                OPC_SYSTEM, OPC_FENCE: begin
                    dec.data_1    = bus.i_rs1_data;
                    dec.is_system = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end

        if (dec.alu_op == ALU_SLL || dec.alu_op == ALU_SRL || dec.alu_op == ALU_SRA)
            dec.shamt = dec.data_2[4:0];

        // Illegal words still issue (for a downstream trap) but as a harmless ADD 0,0.
        if (illegal) begin
            dec         = '0;
            dec.alu_op  = ALU_ADD;
            dec.rd      = instr[11:7];
            dec.illegal = 1'b1;
        end

        if (dec.rd == 5'd0)
            dec.wb_en = 1'b0;
    end

    assign bus.o_ready = !valid_q || bus.i_ready;
    assign load        = bus.i_valid && bus.o_ready && !i_flush;

    always_comb begin
        valid_d = valid_q;
        issue_d = issue_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            issue_d = dec;
        end else if (bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q        <= 1'b0;
            issue_q        <= '0;
            issue_q.alu_op <= ALU_ADD;
        end else begin
            valid_q <= valid_d;
            issue_q <= issue_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_alu_op    = issue_q.alu_op;
    assign bus.o_data_1    = issue_q.data_1;
    assign bus.o_data_2    = issue_q.data_2;
    assign bus.o_shamt     = issue_q.shamt;
    assign bus.o_rd        = issue_q.rd;
    assign bus.o_wb_en     = issue_q.wb_en;
    assign bus.o_is_branch = issue_q.is_branch;
    assign bus.o_imm       = issue_q.imm;
    assign bus.o_is_mem    = issue_q.is_mem;
    assign bus.o_is_system = issue_q.is_system;
    assign bus.o_illegal   = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: hand-decoded instructions, backpressure,
// flush and asynchronous reset during a stall.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   vectors;
    int   miscompares;

    alu_issue_if bus ();

    alu_issue dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one instruction for a single edge, then drops i_valid.
    task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.i_valid    = 1'b1;
        bus.i_instr    = instr;
        bus.i_pc       = pc;
        bus.i_rs1_data = rs1;
        bus.i_rs2_data = rs2;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        $display("issue %-8s instr=%08h pc=%08h rs1=%08h rs2=%08h -> op=%0d d1=%08h d2=%08h",
                 name, instr, pc, rs1, rs2, bus.o_alu_op, bus.o_data_1, bus.o_data_2);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_instr    = 32'h0;
        bus.i_pc       = 32'h0;
        bus.i_rs1_data = 32'h0;
        bus.i_rs2_data = 32'h0;

        #3;
        check("rst_valid",  {31'b0, bus.o_valid}, 32'd0);
        check("rst_ready",  {31'b0, bus.o_ready}, 32'd1);
        check("rst_op",     {28'b0, bus.o_alu_op}, ALU_ADD);
        check("rst_data_1", bus.o_data_1, 32'h0);
        check("rst_wb_en",  {31'b0, bus.o_wb_en}, 32'd0);
        check("rst_illegal", {31'b0, bus.o_illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.i_ready = 1'b1;

        issue("ADD", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("add_valid", {31'b0, bus.o_valid}, 32'd1);
        check("add_op",    {28'b0, bus.o_alu_op}, ALU_ADD);
        check("add_d1",    bus.o_data_1, 32'd5);
        check("add_d2",    bus.o_data_2, 32'd7);
        check("add_rd",    {27'b0, bus.o_rd}, 32'd3);
        check("add_wb",    {31'b0, bus.o_wb_en}, 32'd1);
        check("add_shamt", {27'b0, bus.o_shamt}, 32'd0);

        issue("SRAI", 32'h40335293, 32'h0, 32'h80000000, 32'h0);
        check("srai_op",    {28'b0, bus.o_alu_op}, ALU_SRA);
        check("srai_d1",    bus.o_data_1, 32'h80000000);
        check("srai_d2",    bus.o_data_2, 32'd3);
        check("srai_shamt", {27'b0, bus.o_shamt}, 32'd3);

        issue("SLL", 32'h002093B3, 32'h0, 32'h1, 32'h00000025);
        check("sll_op",    {28'b0, bus.o_alu_op}, ALU_SLL);
        check("sll_d2",    bus.o_data_2, 32'd5);
        check("sll_shamt", {27'b0, bus.o_shamt}, 32'd5);

        issue("BNE", 32'h00209463, 32'h0, 32'd1, 32'd2);
        check("bne_op",  {28'b0, bus.o_alu_op}, ALU_NEQ);
        check("bne_br",  {31'b0, bus.o_is_branch}, 32'd1);
        check("bne_imm", bus.o_imm, 32'd8);
        check("bne_wb",  {31'b0, bus.o_wb_en}, 32'd0);

        issue("LUI", 32'h123450B7, 32'h0, 32'hDEADBEEF, 32'h0);
        check("lui_d1", bus.o_data_1, 32'h0);
        check("lui_d2", bus.o_data_2, 32'h12345000);
        check("lui_wb", {31'b0, bus.o_wb_en}, 32'd1);

        issue("SW", 32'hFE20AE23, 32'h0, 32'h1000, 32'h55);
        check("sw_mem", {31'b0, bus.o_is_mem}, 32'd1);
        check("sw_d1",  bus.o_data_1, 32'h1000);
        check("sw_d2",  bus.o_data_2, 32'hFFFFFFFC);
        check("sw_imm", bus.o_imm, 32'hFFFFFFFC);
        check("sw_wb",  {31'b0, bus.o_wb_en}, 32'd0);

        issue("JAL", 32'h010000EF, 32'h00000100, 32'h0, 32'h0);
        check("jal_d1",  bus.o_data_1, 32'h100);
        check("jal_d2",  bus.o_data_2, 32'd4);
        check("jal_imm", bus.o_imm, 32'd16);
        check("jal_wb",  {31'b0, bus.o_wb_en}, 32'd1);

        issue("ADDI_x0", 32'h00108013, 32'h0, 32'd9, 32'h0);
        check("addi0_d2", bus.o_data_2, 32'd1);
        check("addi0_wb", {31'b0, bus.o_wb_en}, 32'd0);

        issue("ECALL", 32'h00000073, 32'h0, 32'h0, 32'h0);
        check("ecall_sys", {31'b0, bus.o_is_system}, 32'd1);
        check("ecall_wb",  {31'b0, bus.o_wb_en}, 32'd0);

        issue("ILL_FF", 32'hFFFFFFFF, 32'h0, 32'h1234, 32'h5678);
        check("illff_valid", {31'b0, bus.o_valid}, 32'd1);
        check("illff_ill",   {31'b0, bus.o_illegal}, 32'd1);
        check("illff_wb",    {31'b0, bus.o_wb_en}, 32'd0);
        check("illff_d1",    bus.o_data_1, 32'h0);

        issue("ILL_BR2", 32'h0020A463, 32'h0, 32'd1, 32'd2);
        check("illbr_valid", {31'b0, bus.o_valid}, 32'd1);
        check("illbr_ill",   {31'b0, bus.o_illegal}, 32'd1);
        check("illbr_br",    {31'b0, bus.o_is_branch}, 32'd0);
        check("illbr_wb",    {31'b0, bus.o_wb_en}, 32'd0);

        @(posedge clk);
        #1;
        check("drain_valid", {31'b0, bus.o_valid}, 32'd0);

        // Backpressure: ADD held while a LUI waits upstream.
        bus.i_ready = 1'b0;
        issue("ADD_bp", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        bus.i_valid    = 1'b1;
        bus.i_instr    = 32'h123450B7;
        bus.i_rs1_data = 32'h0;
        bus.i_rs2_data = 32'h0;
        for (int c = 0; c < 3; c++) begin
            check("bp_ready", {31'b0, bus.o_ready}, 32'd0);
            @(posedge clk);
            #1;
            check("bp_valid", {31'b0, bus.o_valid}, 32'd1);
            check("bp_d1",    bus.o_data_1, 32'd5);
            check("bp_d2",    bus.o_data_2, 32'd7);
            check("bp_rd",    {27'b0, bus.o_rd}, 32'd3);
        end
        bus.i_ready = 1'b1;
        #1;
        check("bp_ready_rel", {31'b0, bus.o_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        $display("issue %-8s instr=%08h (accepted after stall) -> d2=%08h", "LUI_bp",
                 32'h123450B7, bus.o_data_2);
        check("bp_second_valid", {31'b0, bus.o_valid}, 32'd1);
        check("bp_second_d2",    bus.o_data_2, 32'h12345000);
        check("bp_second_rd",    {27'b0, bus.o_rd}, 32'd1);

        // Flush kills the held op and the same-cycle incoming one.
        bus.i_ready = 1'b0;
        issue("ADD_fl", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("fl_pre_valid", {31'b0, bus.o_valid}, 32'd1);
        flush       = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_instr = 32'h123450B7;
        @(posedge clk);
        #1;
        check("fl_valid", {31'b0, bus.o_valid}, 32'd0);
        flush       = 1'b0;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl_no_load", {31'b0, bus.o_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        issue("ADD_rst", 32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("ar_pre_valid", {31'b0, bus.o_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, bus.o_valid}, 32'd0);
        check("ar_ready", {31'b0, bus.o_ready}, 32'd1);
        check("ar_op",    {28'b0, bus.o_alu_op}, ALU_ADD);
        check("ar_d1",    bus.o_data_1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
